// File: rtl/dct_macu_pipe_if.sv
// Handshake and data bundle for dct_macu_pipe: term input side plus strobed result side.
interface dct_macu_pipe_if #(
  parameter int unsigned A_W   = 12,
  parameter int unsigned B_W   = 11,
  parameter int unsigned RES_W = 24
);
  logic                    ena;
  logic                    clr;
  logic                    in_valid;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic                    out_valid;
  logic signed [RES_W-1:0] result;
  logic                    ovf;

  modport master (
    output ena, clr, in_valid, a, b,
    input  out_valid, result, ovf
  );

  modport slave (
    input  ena, clr, in_valid, a, b,
    output out_valid, result, ovf
  );
endinterface

// File: rtl/dct_macu_pipe.sv
// Pipelined signed multiply-accumulate for the forward DCT: TERMS products per result,
// optional saturation, arithmetic output scaling and a per-block sticky overflow flag.
module dct_macu_pipe #(
  parameter int unsigned A_W   = 12,
  parameter int unsigned B_W   = 11,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned TERMS = 8,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned SAT   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dct_macu_pipe_if.slave bus
);
  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned RES_W = ACC_W - SHIFT;
  localparam int unsigned CNT_W = $clog2(TERMS);

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TERMS - 1);

  logic signed [P_W-1:0]   p_q, p_d;
  logic                    p_v_q, p_v_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    blk_ovf_q, blk_ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [RES_W-1:0] result_q, result_d;
  logic                    ovf_q, ovf_d;

  logic signed [SUM_W-1:0] base;
  logic signed [SUM_W-1:0] sum;
  logic                    sum_of;
  logic signed [ACC_W-1:0] acc_upd;
  logic signed [ACC_W-1:0] acc_scaled;
  logic                    blk_ovf_upd;

  // Exact one-bit-wider sum; the first term of a block starts from zero.
  always_comb begin
    base = '0;
    if (cnt_q != '0) begin
      base = SUM_W'(acc_q);
    end
    sum         = SUM_W'(p_q) + base;
    sum_of      = sum[ACC_W] ^ sum[ACC_W-1];
    acc_upd     = sum[ACC_W-1:0];
    if (sum_of && (SAT != 0)) begin
      acc_upd = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    blk_ovf_upd = sum_of | ((cnt_q != '0) & blk_ovf_q);
    acc_scaled  = acc_upd >>> SHIFT;
  end

  // Next state, assuming an enabled edge; clr overrides any term in flight.
  always_comb begin
    p_d         = p_q;
    p_v_d       = bus.in_valid & ~bus.clr;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    blk_ovf_d   = blk_ovf_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    ovf_d       = ovf_q;

    if (bus.in_valid && !bus.clr) begin
      p_d = P_W'(bus.a) * P_W'(bus.b);
    end

    if (bus.clr) begin
      cnt_d     = '0;
      acc_d     = '0;
      blk_ovf_d = 1'b0;
    end else if (p_v_q) begin
      acc_d     = acc_upd;
      blk_ovf_d = blk_ovf_upd;
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        result_d    = RES_W'(acc_scaled);
        ovf_d       = blk_ovf_upd;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q         <= '0;
      p_v_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      blk_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else if (bus.ena) begin
      p_q         <= p_d;
      p_v_q       <= p_v_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      blk_ovf_q   <= blk_ovf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
endmodule
